decode_stage_multi: RTL and testbench
=====================================

// Module: decode_stage_multi
// PURPOSE
//  Parametrised N-wide decode stage for the superscalar core. It sits between fetch and issue.
//  Decodes ISSUE_W 16-bit instructions per cycle, reads operands via an external RF, computes branch targets.
//  Registers the results behind a valid/ready handshake.
//  Splits a bundle when a younger lane reads an older lane's rd. Supports stall and branch flush.
// PARAMETERS
//  ISSUE_W  2   lanes per bundle (>=1)
//  XLEN     16  register/operand width (>=16)
//  PC_W     16  program-counter width
// PORTS
//  clk               in   1               rising-edge clock
//  reset_n           in   1               asynchronous, active-low reset
//  flush             in   1               branch taken: kill in-flight decode state
//  in_valid          in   1               fetch bundle valid
//  in_ready          out  1               stage accepts bundle this cycle
//  in_lane_valid     in   ISSUE_W         per-lane valid within bundle
//  in_instr          in   16*ISSUE_W      lane i = [16i+15:16i]
//  in_pc             in   PC_W            pc of lane 0; lane i pc = in_pc+i
//  rf_raddr          out  6*ISSUE_W       lane i: [6i+2:6i]=rs1, [6i+5:6i+3]=rs2 (combinational)
//  rf_rdata          in   2*XLEN*ISSUE_W  same-cycle read data, matching rf_raddr order
//  out_ready         in   1               issue accepts (low = stall)
//  out_valid         out  ISSUE_W         per-lane decoded valid
//  out_opcode        out  4*ISSUE_W       opcode per lane
//  out_rd            out  3*ISSUE_W       destination register per lane
//  out_imm           out  5*ISSUE_W       raw imm5 per lane
//  out_op1/out_op2   out  XLEN*ISSUE_W    operand values per lane
//  out_is_branch     out  ISSUE_W         opcode==4'b1100
//  out_branch_target out  PC_W*ISSUE_W    lane pc + sext(imm5), else 0
//  out_pc            out  PC_W*ISSUE_W    pc of each decoded lane
// BEHAVIOUR
//  Encoding
//   [15:12] opcode; [11] imm_flag; [10:8] rd; [7:5] rs1; [4:2] rs2; [4:0] imm5.
//  Operands
//   op1 = rf[rs1].
//   op2 = imm_flag ? sext(imm5) to XLEN : rf[rs2].
//  Writers
//   A lane writes rd unless its opcode is 0000 (NOP), 1100 (BR) or 1101 (ST).
//  Branch target
//   Lane pc + sext(imm5), taken modulo 2^PC_W.
//  Reset
//   All out_* = 0; state = RUN; hold register empty.
//  Latency and advance
//   One cycle from accept to out_valid.
//   adv = out_ready | ~|out_valid.
//   When adv is low, every out_* holds stable.
//  in_ready
//   in_ready = adv & (state==RUN) & ~flush.
//   An input is consumed only when in_valid & in_ready.
//  Hazard check (source = input bundle, or hold register in SPLIT)
//   Lane j>0 is dependent if it reads rs1, or rs2 when imm_flag=0, equal to rd of a valid writer k<j in the same group.
//   j* = the first dependent lane.
//  States
//   RUN -> SPLIT: a hazard exists on accept.
//    Lanes <j* go to the output; lanes >=j* move into the hold register, shifted down to lane 0.
//   SPLIT -> SPLIT: on adv, the held group issues under the same rule; a further hazard splits it again.
//   SPLIT -> RUN: on adv, the held group issues fully.
//  RF reads
//   rf_raddr is driven from the group being latched this cycle (input or hold).
//   Held lanes therefore read fresh RF data.
//  Flush (highest priority, synchronous)
//   Next edge: out_valid = 0, hold cleared, state = RUN.
//   in_ready = 0 during flush; in_* is ignored.
//  Lanes
//   A lane with in_lane_valid=0 yields out_valid=0 and is never a hazard source.
//   NOP lanes still propagate valid.
//  Reset mid-SPLIT
//   Held lanes are discarded.
// TESTING
//  T1 Reset
//   Hold reset_n=0 and drive in_valid=1 -> all out_*=0, in_ready=0; release -> in_ready=1.
//  T2 Immediate
//   lane0=0x1943, rf[r2]=0x0010, out_ready=1 -> next cycle: out_valid[0]=1, opcode=0001, rd=1, op1=0x0010, op2=0x0003.
//  T3 Branch
//   lane0=0xC81E, in_pc=0x0020 -> is_branch=1, target=0x001E; lane1 non-branch -> target=0.
//  T4 Split
//   lane0=0x1943, lane1=0x2324 -> cycle1: out_valid=01, in_ready=0.
//   cycle2: out_valid=01, lane0 opcode=0010, pc=in_pc+1, op1=rf[r1] from the cycle-2 read.
//  T5 Stall
//   out_ready=0 with valid outputs -> outputs unchanged for 3 cycles, in_ready=0; release -> next bundle is accepted.
//  T6 Flush
//   Assert flush in SPLIT -> next cycle: out_valid=0, state RUN, in_ready=1; no held lane ever appears.

Source files
------------

// File: rtl/decode_stage_multi.sv
// decode_stage_multi: N-wide decode stage between fetch and issue, with RF operand read,
// branch-target generation and bundle splitting on intra-bundle RAW hazards.
module decode_stage_multi #(
   parameter int ISSUE_W = 2,
   parameter int XLEN    = 16,
   parameter int PC_W    = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ISSUE_W-1:0]          in_lane_valid,
   input  logic [16*ISSUE_W-1:0]       in_instr,
   input  logic [PC_W-1:0]             in_pc,
   output logic [6*ISSUE_W-1:0]        rf_raddr,
   input  logic [2*XLEN*ISSUE_W-1:0]   rf_rdata,
   input  logic                        out_ready,
   output logic [ISSUE_W-1:0]          out_valid,
   output logic [4*ISSUE_W-1:0]        out_opcode,
   output logic [3*ISSUE_W-1:0]        out_rd,
   output logic [5*ISSUE_W-1:0]        out_imm,
   output logic [XLEN*ISSUE_W-1:0]     out_op1,
   output logic [XLEN*ISSUE_W-1:0]     out_op2,
   output logic [ISSUE_W-1:0]          out_is_branch,
   output logic [PC_W*ISSUE_W-1:0]     out_branch_target,
   output logic [PC_W*ISSUE_W-1:0]     out_pc
);
   localparam int CW = $clog2(ISSUE_W + 1);
   typedef enum logic {RUN, SPLIT} state_t;
   state_t                      r_state, w_next_state;
   logic [ISSUE_W-1:0]          r_hold_valid;
   logic [16*ISSUE_W-1:0]       r_hold_instr;
   logic [PC_W-1:0]             r_hold_pc;
   logic [ISSUE_W-1:0]          w_src_valid;
   logic [16*ISSUE_W-1:0]       w_src_instr;
   logic [PC_W-1:0]             w_src_pc;
   logic                        w_adv, w_latch, w_split;
   logic [ISSUE_W-1:0]          w_dep, w_issue, w_writer, w_immf;
   logic [CW-1:0]               w_cut;
   logic [2:0]                  w_rd [ISSUE_W];
   logic [2:0]                  w_rs1 [ISSUE_W];
   logic [2:0]                  w_rs2 [ISSUE_W];
   logic [4*ISSUE_W-1:0]        w_n_opcode;
   logic [3*ISSUE_W-1:0]        w_n_rd;
   logic [5*ISSUE_W-1:0]        w_n_imm;
   logic [XLEN*ISSUE_W-1:0]     w_n_op1, w_n_op2;
   logic [ISSUE_W-1:0]          w_n_br;
   logic [PC_W*ISSUE_W-1:0]     w_n_tgt, w_n_pc;

   assign w_src_valid = (r_state == SPLIT) ? r_hold_valid : in_lane_valid;
   assign w_src_instr = (r_state == SPLIT) ? r_hold_instr : in_instr;
   assign w_src_pc    = (r_state == SPLIT) ? r_hold_pc : in_pc;
   assign w_adv       = out_ready | ~|out_valid;
   assign in_ready    = reset_n & w_adv & (r_state == RUN) & ~flush;
   assign w_latch     = ~flush & w_adv & ((r_state == SPLIT) | in_valid);
   assign w_split     = |w_dep;

   for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
      logic [15:0]     w_ins;
      logic [PC_W-1:0] w_pc, w_off;
      logic [XLEN-1:0] w_sext;
      logic            w_br;
      assign w_ins       = w_src_instr[16*g +: 16];
      assign w_rd[g]     = w_ins[10:8];
      assign w_rs1[g]    = w_ins[7:5];
      assign w_rs2[g]    = w_ins[4:2];
      assign w_immf[g]   = w_ins[11];
      assign w_br        = w_ins[15:12] == 4'b1100;
      assign w_writer[g] = (w_ins[15:12] != 4'b0000) & ~w_br & (w_ins[15:12] != 4'b1101);
      assign w_pc        = w_src_pc + PC_W'(g);
      assign w_sext      = {{(XLEN-5){w_ins[4]}}, w_ins[4:0]};
      assign w_off       = {{(PC_W-5){w_ins[4]}}, w_ins[4:0]};
      assign rf_raddr[6*g +: 6]           = {w_ins[4:2], w_ins[7:5]};
      assign w_n_opcode[4*g +: 4]         = w_issue[g] ? w_ins[15:12] : 4'b0;
      assign w_n_rd[3*g +: 3]             = w_issue[g] ? w_ins[10:8] : 3'b0;
      assign w_n_imm[5*g +: 5]            = w_issue[g] ? w_ins[4:0] : 5'b0;
      assign w_n_op1[XLEN*g +: XLEN]      = w_issue[g] ? rf_rdata[2*XLEN*g +: XLEN] : '0;
      assign w_n_op2[XLEN*g +: XLEN]      = ~w_issue[g] ? '0 : w_ins[11] ? w_sext : rf_rdata[2*XLEN*g+XLEN +: XLEN];
      assign w_n_br[g]                    = w_issue[g] & w_br;
      assign w_n_tgt[PC_W*g +: PC_W]      = (w_issue[g] & w_br) ? w_pc + w_off : '0;
      assign w_n_pc[PC_W*g +: PC_W]       = w_issue[g] ? w_pc : '0;
   end

   // Lanes at or beyond the first dependent lane (w_cut) are deferred to the hold register.
   always_comb begin
      w_dep = '0;
      for (int j = 1; j < ISSUE_W; j++)
         for (int k = 0; k < j; k++)
            if (w_src_valid[j] & w_src_valid[k] & w_writer[k] &
                ((w_rs1[j] == w_rd[k]) | (~w_immf[j] & (w_rs2[j] == w_rd[k]))))
               w_dep[j] = 1'b1;
      w_cut = CW'(ISSUE_W);
      for (int j = ISSUE_W - 1; j > 0; j--)
         if (w_dep[j]) w_cut = CW'(j);
      w_issue = '0;
      for (int i = 0; i < ISSUE_W; i++)
         w_issue[i] = w_src_valid[i] & (CW'(i) < w_cut);
   end

   always_comb begin
      w_next_state = r_state;
      if (flush) w_next_state = RUN;
      else if (w_latch) w_next_state = w_split ? SPLIT : RUN;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= RUN;
      else r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_valid      <= '0;
         r_hold_instr      <= '0;
         r_hold_pc         <= '0;
         out_valid         <= '0;
         out_opcode        <= '0;
         out_rd            <= '0;
         out_imm           <= '0;
         out_op1           <= '0;
         out_op2           <= '0;
         out_is_branch     <= '0;
         out_branch_target <= '0;
         out_pc            <= '0;
      end else if (flush) begin
         r_hold_valid <= '0;
         out_valid    <= '0;
      end else if (w_latch) begin
         r_hold_valid      <= w_split ? (w_src_valid >> w_cut) : '0;
         r_hold_instr      <= w_src_instr >> (16 * w_cut);
         r_hold_pc         <= w_src_pc + PC_W'(w_cut);
         out_valid         <= w_issue;
         out_opcode        <= w_n_opcode;
         out_rd            <= w_n_rd;
         out_imm           <= w_n_imm;
         out_op1           <= w_n_op1;
         out_op2           <= w_n_op2;
         out_is_branch     <= w_n_br;
         out_branch_target <= w_n_tgt;
         out_pc            <= w_n_pc;
      end else if (w_adv) begin
         out_valid <= '0;
      end
   end
endmodule

// File: tb/tb_decode_stage_multi.sv
// tb_decode_stage_multi: directed scenarios plus randomized bundles checked against a
// lane-queue reference model of the decode stage.
module tb_decode_stage_multi;
   localparam int IW = 2, XL = 16, PW = 16;
   logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready;
   logic [IW-1:0] in_lane_valid = '0;
   logic [16*IW-1:0] in_instr = '0;
   logic [PW-1:0] in_pc = '0;
   logic [6*IW-1:0] rf_raddr;
   logic [2*XL*IW-1:0] rf_rdata;
   logic [IW-1:0] out_valid, out_is_branch;
   logic [4*IW-1:0] out_opcode;
   logic [3*IW-1:0] out_rd;
   logic [5*IW-1:0] out_imm;
   logic [XL*IW-1:0] out_op1, out_op2;
   logic [PW*IW-1:0] out_branch_target, out_pc;
   logic [XL-1:0] rf [8];

   always #5 clk = ~clk;

   decode_stage_multi #(.ISSUE_W(IW), .XLEN(XL), .PC_W(PW)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_pc(in_pc),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_ready(out_ready), .out_valid(out_valid),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_imm(out_imm), .out_op1(out_op1),
      .out_op2(out_op2), .out_is_branch(out_is_branch), .out_branch_target(out_branch_target),
      .out_pc(out_pc));

   always_comb
      for (int i = 0; i < IW; i++) begin
         rf_rdata[2*XL*i +: XL]      = rf[rf_raddr[6*i +: 3]];
         rf_rdata[2*XL*i + XL +: XL] = rf[rf_raddr[6*i + 3 +: 3]];
      end

   typedef struct {logic v; logic [15:0] ins; logic [PW-1:0] pc;} lane_t;
   lane_t hold[$];
   logic [IW-1:0] m_valid = '0, m_br;
   logic [3:0] m_opc [IW];
   logic [2:0] m_rd [IW];
   logic [4:0] m_imm [IW];
   logic [XL-1:0] m_op1 [IW], m_op2 [IW];
   logic [PW-1:0] m_tgt [IW], m_pc [IW];
   int n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit writes(input logic [15:0] ins);
      return ins[15:12] != 4'h0 && ins[15:12] != 4'hC && ins[15:12] != 4'hD;
   endfunction

   function automatic bit reads(input logic [15:0] ins, input logic [2:0] r);
      return ins[7:5] == r || (!ins[11] && ins[4:2] == r);
   endfunction

   // Computes the expected outputs after the coming edge from the inputs now applied.
   task automatic model_step();
      bit adv;
      lane_t g[$];
      int cut;
      adv = out_ready || m_valid == '0;
      check("in_ready", 64'(in_ready), 64'(adv && hold.size() == 0 && !flush));
      if (flush) begin
         m_valid = '0;
         hold.delete();
      end else if (adv && (hold.size() > 0 || in_valid)) begin
         if (hold.size() > 0) g = hold;
         else for (int i = 0; i < IW; i++)
            g.push_back('{v: in_lane_valid[i], ins: in_instr[16*i +: 16], pc: in_pc + PW'(i)});
         cut = g.size();
         for (int j = 1; j < g.size(); j++)
            if (cut == g.size())
               for (int k = 0; k < j; k++)
                  if (g[j].v && g[k].v && writes(g[k].ins) && reads(g[j].ins, g[k].ins[10:8])) cut = j;
         m_valid = '0;
         for (int i = 0; i < IW; i++)
            if (i < cut && g[i].v) begin
               logic [15:0] x;
               x = g[i].ins;
               m_valid[i] = 1'b1;
               m_opc[i] = x[15:12];
               m_rd[i]  = x[10:8];
               m_imm[i] = x[4:0];
               m_op1[i] = rf[x[7:5]];
               m_op2[i] = x[11] ? XL'(signed'(x[4:0])) : rf[x[4:2]];
               m_br[i]  = x[15:12] == 4'hC;
               m_pc[i]  = g[i].pc;
               m_tgt[i] = m_br[i] ? g[i].pc + PW'(signed'(x[4:0])) : '0;
            end
         hold.delete();
         for (int i = cut; i < g.size(); i++) hold.push_back(g[i]);
      end else if (adv) m_valid = '0;
   endtask

   task automatic compare_all();
      for (int i = 0; i < IW; i++) begin
         check($sformatf("valid%0d", i), 64'(out_valid[i]), 64'(m_valid[i]));
         if (m_valid[i]) begin
            check($sformatf("opcode%0d", i), 64'(out_opcode[4*i +: 4]), 64'(m_opc[i]));
            check($sformatf("rd%0d", i), 64'(out_rd[3*i +: 3]), 64'(m_rd[i]));
            check($sformatf("imm%0d", i), 64'(out_imm[5*i +: 5]), 64'(m_imm[i]));
            check($sformatf("op1_%0d", i), 64'(out_op1[XL*i +: XL]), 64'(m_op1[i]));
            check($sformatf("op2_%0d", i), 64'(out_op2[XL*i +: XL]), 64'(m_op2[i]));
            check($sformatf("br%0d", i), 64'(out_is_branch[i]), 64'(m_br[i]));
            check($sformatf("tgt%0d", i), 64'(out_branch_target[PW*i +: PW]), 64'(m_tgt[i]));
            check($sformatf("pc%0d", i), 64'(out_pc[PW*i +: PW]), 64'(m_pc[i]));
         end
      end
   endtask

   task automatic tick();
      #2;
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive_rand();
      in_valid = $urandom_range(0, 3) != 0;
      in_lane_valid = ($urandom_range(0, 3) == 0) ? IW'($urandom) : '1;
      for (int i = 0; i < IW; i++) in_instr[16*i +: 16] = 16'($urandom);
      in_pc = PW'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      for (int r = 0; r < 8; r++) rf[r] = XL'($urandom);
   endtask

   initial begin
      for (int r = 0; r < 8; r++) rf[r] = XL'($urandom);
      in_valid = 1'b1;
      in_lane_valid = '1;
      in_instr = 32'h1943_2324;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_opcode", 64'(out_opcode), 64'(0));
      check("rst_op1", 64'(out_op1), 64'(0));
      check("rst_tgt", 64'(out_branch_target), 64'(0));
      @(negedge clk) reset_n = 1'b1;
      #1 check("rel_in_ready", 64'(in_ready), 64'(1));

      // immediate operand
      in_lane_valid = 2'b01; in_instr = {16'h0000, 16'h1943}; in_pc = 16'h0100; rf[2] = 16'h0010;
      tick();
      check("t2_valid", 64'(out_valid), 64'(2'b01));
      check("t2_opcode", 64'(out_opcode[3:0]), 64'(1));
      check("t2_rd", 64'(out_rd[2:0]), 64'(1));
      check("t2_op1", 64'(out_op1[15:0]), 64'(16'h0010));
      check("t2_op2", 64'(out_op2[15:0]), 64'(16'h0003));

      // branch target
      in_lane_valid = 2'b11; in_instr = {16'h1000, 16'hC81E}; in_pc = 16'h0020;
      tick();
      check("t3_br", 64'(out_is_branch), 64'(2'b01));
      check("t3_tgt0", 64'(out_branch_target[15:0]), 64'(16'h001E));
      check("t3_tgt1", 64'(out_branch_target[31:16]), 64'(0));

      // bundle split
      in_instr = {16'h2324, 16'h1943}; in_pc = 16'h0040;
      tick();
      check("t4_valid1", 64'(out_valid), 64'(2'b01));
      check("t4_in_ready", 64'(in_ready), 64'(0));
      rf[1] = 16'h5A5A; in_valid = 1'b0;
      tick();
      check("t4_valid2", 64'(out_valid), 64'(2'b01));
      check("t4_opcode", 64'(out_opcode[3:0]), 64'(2));
      check("t4_pc", 64'(out_pc[15:0]), 64'(16'h0041));
      check("t4_op1", 64'(out_op1[15:0]), 64'(16'h5A5A));

      // stall
      in_valid = 1'b1; in_instr = {16'h3000, 16'h1111}; in_pc = 16'h0080;
      tick();
      out_ready = 1'b0; in_instr = {16'h4222, 16'h5333};
      repeat (3) begin
         tick();
         check("t5_in_ready", 64'(in_ready), 64'(0));
         check("t5_hold_pc", 64'(out_pc[15:0]), 64'(16'h0080));
      end
      out_ready = 1'b1;
      tick();
      check("t5_next_opcode", 64'(out_opcode[3:0]), 64'(5));

      // flush while split
      in_instr = {16'h2324, 16'h1943}; in_pc = 16'h0090;
      tick();
      flush = 1'b1;
      tick();
      check("t6_valid", 64'(out_valid), 64'(0));
      flush = 1'b0; in_valid = 1'b0;
      #1 check("t6_in_ready", 64'(in_ready), 64'(1));
      tick();
      check("t6_no_held", 64'(out_valid), 64'(0));

      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            #3 reset_n = 1'b0;
            #1;
            check("midrst_valid", 64'(out_valid), 64'(0));
            check("midrst_in_ready", 64'(in_ready), 64'(0));
            m_valid = '0;
            hold.delete();
            @(negedge clk) reset_n = 1'b1;
         end
         drive_rand();
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
